// File: rtl/sync_fifo_pkg.sv
// Shared constants for the sync_fifo slice.
// Holds the default word width, depth and almost-empty threshold.
// These defaults are picked up by sync_fifo and fifo_mem.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_W        = 8;
    localparam int DEFAULT_DEPTH         = 8;
    localparam int DEFAULT_AEMPTY_THRESH = 2;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage for sync_fifo.
// The memory has one synchronous write port and one synchronous read port.
// The read port has a registered output that holds its value between reads.
// The array itself is never cleared; only the output register resets.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write; the contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read: a same-edge write to this address is not visible until the next read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO.
// The FIFO tracks occupancy and decodes all flags from the registered count.
// Define SYNC_FIFO_ERR_EN to add the sticky overflow and underflow ports.
// Reset is asynchronous and active-low on the port rst.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
`ifdef SYNC_FIFO_ERR_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL_LVL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] AEMPT_LVL = (ADDR_W+1)'(AEMPTY_THRESH);

    // Pointers carry a wrap bit above the address bits
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            wr_acc;
    logic            rd_acc;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge;
    // an empty FIFO never forwards a same-edge write straight to data_out
    always_comb begin
        rd_acc = read && !empty;
        wr_acc = write && (!full || rd_acc);
    end

    // Pointer advance on each accepted transfer, wrapping naturally modulo 2*DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    // Occupancy moves only when exactly one side transfers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Flags are pure decodes of the count register, so there is no path from request inputs to flags
    always_comb begin
        full         = (count == FULL_LVL);
        empty        = (count == '0);
        almost_full  = (count >= AFULL_LVL);
        almost_empty = (count <= AEMPT_LVL);
    end

`ifdef SYNC_FIFO_ERR_EN
    // Sticky record of dropped requests, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && full && !read) begin
                overflow <= 1'b1;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (data_out)
    );

endmodule
